// File: rtl/alu_reg16.sv
// Registered integer ALU for the execute stage: one operation per cycle,
// result and flags captured one clock after the operands are presented.
module alu_reg16 #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] Bus_A_ALU,
  input  logic [WIDTH-1:0] Bus_B_ALU,
  input  logic [3:0]       ALU_control,
  output logic [WIDTH-1:0] ALU_out,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             out_valid
);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_SLT = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;

  logic signed [WIDTH-1:0] a_p0;
  logic signed [WIDTH-1:0] b_p0;
  logic        [SHW-1:0]   shamt_p0;
  logic        [WIDTH:0]   sum_p0;
  logic        [WIDTH:0]   dif_p0;
  logic        [WIDTH-1:0] res_p0;
  logic                    carry_p0;
  logic                    ovf_p0;

  logic        [WIDTH-1:0] res_p1;
  logic                    zero_p1;
  logic                    carry_p1;
  logic                    ovf_p1;
  logic                    vld_p1;

  assign a_p0     = Bus_A_ALU;
  assign b_p0     = Bus_B_ALU;
  assign shamt_p0 = Bus_B_ALU[SHW-1:0];
  // Extra top bit is the carry-out for ADD and the borrow for SUB.
  assign sum_p0   = {1'b0, Bus_A_ALU} + {1'b0, Bus_B_ALU};
  assign dif_p0   = {1'b0, Bus_A_ALU} - {1'b0, Bus_B_ALU};

  always_comb begin
    res_p0   = '0;
    carry_p0 = 1'b0;
    ovf_p0   = 1'b0;
    unique case (ALU_control)
      OP_AND: res_p0 = Bus_A_ALU & Bus_B_ALU;
      OP_OR:  res_p0 = Bus_A_ALU | Bus_B_ALU;
      OP_ADD: begin
        res_p0   = sum_p0[WIDTH-1:0];
        carry_p0 = sum_p0[WIDTH];
        ovf_p0   = (a_p0[WIDTH-1] == b_p0[WIDTH-1]) &&
                   (sum_p0[WIDTH-1] != a_p0[WIDTH-1]);
      end
      OP_SUB: begin
        res_p0   = dif_p0[WIDTH-1:0];
        carry_p0 = dif_p0[WIDTH];
        ovf_p0   = (a_p0[WIDTH-1] != b_p0[WIDTH-1]) &&
                   (dif_p0[WIDTH-1] != a_p0[WIDTH-1]);
      end
      OP_SLT: res_p0 = {{(WIDTH-1){1'b0}}, (a_p0 < b_p0)};
      OP_NOR: res_p0 = ~(Bus_A_ALU | Bus_B_ALU);
      OP_XOR: res_p0 = Bus_A_ALU ^ Bus_B_ALU;
      OP_SLL: res_p0 = Bus_A_ALU << shamt_p0;
      OP_SRL: res_p0 = Bus_A_ALU >> shamt_p0;
      OP_SRA: res_p0 = a_p0 >>> shamt_p0;
      default: res_p0 = '0;
    endcase
  end

  // Stage p0 -> p1: output registers, held while no valid operation arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p1   <= '0;
      zero_p1  <= 1'b1;
      carry_p1 <= 1'b0;
      ovf_p1   <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        res_p1   <= res_p0;
        zero_p1  <= (res_p0 == '0);
        carry_p1 <= carry_p0;
        ovf_p1   <= ovf_p0;
      end
    end
  end

  assign ALU_out   = res_p1;
  assign zero      = zero_p1;
  assign carry     = carry_p1;
  assign overflow  = ovf_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_alu_reg16.sv
// Directed bench for alu_reg16: vector table for single operations, plus
// hand-written sequences for reset, hold on bubbles and restart.
module tb_alu_reg16;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        z;
    logic        c;
    logic        v;
  } vec_t;

  localparam int NV = 22;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] bus_a;
  logic [15:0] bus_b;
  logic [3:0]  alu_control;
  logic [15:0] alu_out;
  logic        zero;
  logic        carry;
  logic        overflow;
  logic        out_valid;

  int errors = 0;
  int checks = 0;
  vec_t vecs [NV];

  alu_reg16 #(.WIDTH(16), .SHW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .Bus_A_ALU  (bus_a),
    .Bus_B_ALU  (bus_b),
    .ALU_control(alu_control),
    .ALU_out    (alu_out),
    .zero       (zero),
    .carry      (carry),
    .overflow   (overflow),
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] r, input logic z,
                           input logic c, input logic v, input logic ov);
    check({tag, ".out"},   32'(alu_out),   32'(r));
    check({tag, ".zero"},  32'(zero),      32'(z));
    check({tag, ".carry"}, 32'(carry),     32'(c));
    check({tag, ".ovf"},   32'(overflow),  32'(v));
    check({tag, ".vld"},   32'(out_valid), 32'(ov));
  endtask

  task automatic drive(input logic vld, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    in_valid    = vld;
    alu_control = op;
    bus_a       = a;
    bus_b       = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            op     a         b         r        z     c     v
    vecs[0]  = '{4'd0,  16'hC000, 16'hFFFF, 16'hC000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'd1,  16'hC000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{4'd5,  16'hC000, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{4'd6,  16'hC000, 16'hFFFF, 16'h3FFF, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'd2,  16'hC000, 16'hFFFF, 16'hBFFF, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{4'd3,  16'hC000, 16'hFFFF, 16'hC001, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{4'd4,  16'hC000, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'd2,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{4'd3,  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{4'd3,  16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{4'd7,  16'hC000, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{4'd8,  16'hC000, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{4'd9,  16'hC000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{4'd7,  16'hC000, 16'hFFF0, 16'hC000, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{4'd8,  16'hC000, 16'hFFF0, 16'hC000, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{4'd9,  16'hC000, 16'hFFF0, 16'hC000, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{4'd9,  16'h8000, 16'h0004, 16'hF800, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{4'd8,  16'h8000, 16'h0004, 16'h0800, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{4'd12, 16'hC000, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{4'd2,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[21] = '{4'd6,  16'h1234, 16'h00FF, 16'h12CB, 1'b0, 1'b0, 1'b0};

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    alu_control = 4'd0;
    bus_a       = 16'h0;
    bus_b       = 16'h0;
    #12;
    check_all("reset", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 4'd2, 16'h1111, 16'h2222);
    drive(1'b0, 4'd2, 16'h1111, 16'h2222);
    check_all("post_reset_idle", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      check_all($sformatf("vec%0d", i), vecs[i].r, vecs[i].z, vecs[i].c, vecs[i].v, 1'b1);
    end

    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'd2, 16'h7FFF, 16'h0001);
      check_all($sformatf("hold%0d", i), 16'h12CB, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    drive(1'b1, 4'd0, 16'hF0F0, 16'h0FF0);
    check_all("restart", 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b1);

    drive(1'b1, 4'd2, 16'h7FFF, 16'h0001);
    check_all("pre_async", 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("rst_held", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    drive(1'b0, 4'd2, 16'h7FFF, 16'h0001);
    drive(1'b0, 4'd2, 16'h7FFF, 16'h0001);
    check_all("release_idle", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
